di2key_pulser: RTL and testbench
================================

// Module: di2key_pulser
// PURPOSE
//   Converts a 2-bit key index (di) back into a timed one-hot key press on a 4-bit keys bus.
//   It is the driving end of the key2di path: each accepted command becomes a press of HOLD_CYCLES cycles.
//   The press is followed by a release gap of GAP_CYCLES cycles with keys = 0.
//   Used to replay key sequences into key2di and other keys-consuming logic without physical buttons.
// PARAMETERS
//   HOLD_CYCLES  4  cycles keys is held one-hot per press; legal range >= 1
//   GAP_CYCLES   2  cycles keys is forced to 4'b0000 after each press; legal range >= 1
//   CNT_W is a localparam = $clog2(max(HOLD_CYCLES,GAP_CYCLES)+1). It is not overridable.
// PORTS
//   clk       in   1  single clock; all state updates on the rising edge
//   rst       in   1  synchronous reset, active-high
//   di_valid  in   1  command valid; the sender holds di stable until the command is accepted
//   di        in   2  key index: 0 -> 4'b0001, 1 -> 4'b0010, 2 -> 4'b0100, 3 -> 4'b1000
//   di_ready  out  1  high in IDLE; a command is accepted on an edge where di_valid & di_ready
//   cancel    in   1  abort the press in progress; acts only in PRESS
//   keys      out  4  registered one-hot key output; never has more than one bit set
//   busy      out  1  high when state != IDLE
//   done      out  1  one-cycle pulse when a press+gap sequence completes
// BEHAVIOUR
//   Reset (rst=1 at an edge):
//     - Next cycle: state=IDLE, keys=0, di_ready=1, busy=0, done=0, counter=0.
//     - This holds at any time, including mid-PRESS or mid-RELEASE.
//     - An in-flight command is dropped and no done pulse is produced.
//     - rst has priority over every other input.
//   FSM states: IDLE, PRESS, RELEASE. All outputs are registered or decoded directly from state.
//     - IDLE:    di_ready=1, keys=0. On accept at edge T0: latch di, go to PRESS, counter=0.
//                keys = 1<<di from cycle T0+1 (latency 1).
//     - PRESS:   keys holds the latched one-hot value. The counter increments each cycle.
//                After HOLD_CYCLES cycles in PRESS (edge T0+HOLD_CYCLES), go to RELEASE and set keys=0.
//     - RELEASE: keys=0 for GAP_CYCLES cycles. At edge T0+HOLD_CYCLES+GAP_CYCLES, go to IDLE.
//                done=1 for exactly that first IDLE cycle.
//   Handshake:
//     - di_valid while di_ready=0 is ignored, not queued.
//     - di is sampled only on the accept edge; later changes to di do not affect the press.
//     - di_ready and done are both high in the completion cycle. A command presented then is
//       accepted at the next edge (back-to-back period = HOLD_CYCLES+GAP_CYCLES+1).
//   Cancel:
//     - In PRESS: next edge goes to RELEASE, counter=0, keys=0. The full GAP_CYCLES gap then runs
//       and done pulses normally.
//     - Ignored in IDLE and in RELEASE.
//     - In IDLE, cancel together with di_valid: the command is accepted and cancel has no effect.
//   Counter: saturates only by the state transition and never wraps within a state.
//   keys is never driven with two bits set, including across transitions.
// TESTING (HOLD_CYCLES=4, GAP_CYCLES=2)
//   1. Reset: rst=1 for 2 cycles
//      -> keys=4'b0000, di_ready=1, busy=0, done=0 from the first edge onward.
//   2. Single press: di=2, di_valid=1 for one cycle (accept at T0)
//      -> keys=4'b0100 in cycles T0+1..T0+4; keys=0 in T0+5..T0+6; done=1 only in cycle T0+7.
//   3. Sweep: di=0,1,2,3, each held with di_valid until accepted
//      -> keys = 0001, 0010, 0100, 1000, 4 cycles each, separated by 3 zero cycles; 4 done pulses.
//   4. Cancel: cancel=1 in the 2nd PRESS cycle
//      -> keys=0 from the next cycle; 2 gap cycles; then done=1 once.
//   5. Reset mid-press: rst=1 during PRESS with keys=4'b1000
//      -> keys=0 and di_ready=1 next cycle; no done pulse.
//   6. Busy ignore: di=3, di_valid=1 during RELEASE, dropped before IDLE
//      -> keys stays 0, no new press starts.
//   Every test also feeds keys into key2di and checks di equals the latched index whenever keys != 0.

Source files
------------

// File: rtl/di2key_pulser.sv
// Replays a 2-bit key index as a timed one-hot press on a 4-bit keys bus:
// HOLD_CYCLES of one-hot keys, then GAP_CYCLES of keys=0, then a one-cycle done pulse.
module di2key_pulser #(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       di_valid,
  input  logic [1:0] di,
  output logic       di_ready,
  input  logic       cancel,
  output logic [3:0] keys,
  output logic       busy,
  output logic       done,
  output logic [1:0] dbg_state
);

  localparam int MAX_CYCLES = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESS   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [3:0]       keys_n;
  logic             done_n;

  // Handshake: a command transfers on a rising edge where di_valid && di_ready;
  // di_ready is high exactly in IDLE, and di is sampled only on that edge.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    keys_n  = keys;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        keys_n = 4'b0000;
        if (di_valid) begin
          state_n = PRESS;
          cnt_n   = '0;
          keys_n  = 4'b0001 << di;
        end
      end
      PRESS: begin
        // Cancel on the final hold cycle lands in the same place as the natural exit.
        if (cancel || (cnt == CNT_W'(HOLD_CYCLES - 1))) begin
          state_n = RELEASE;
          cnt_n   = '0;
          keys_n  = 4'b0000;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      RELEASE: begin
        keys_n = 4'b0000;
        if (cnt == CNT_W'(GAP_CYCLES - 1)) begin
          state_n = IDLE;
          cnt_n   = '0;
          done_n  = 1'b1;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
        keys_n  = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      keys  <= 4'b0000;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      keys  <= keys_n;
      done  <= done_n;
    end
  end

  assign di_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_di2key_pulser.sv
// Bench for di2key_pulser: fixed vector table, directed corner sequences and random
// traffic, all checked against a timeline model of press/release windows.
module tb_di2key_pulser;

  localparam int H = 4;
  localparam int G = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       di_valid = 1'b0;
  logic [1:0] di = 2'd0;
  logic       cancel = 1'b0;
  logic       di_ready, busy, done;
  logic [3:0] keys;
  logic [1:0] dbg_state;

  di2key_pulser #(.HOLD_CYCLES(H), .GAP_CYCLES(G)) dut (
    .clk(clk), .rst(rst), .di_valid(di_valid), .di(di), .di_ready(di_ready),
    .cancel(cancel), .keys(keys), .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Timeline model: a press accepted at edge acc shows keys until edge pend,
  // and the unit is idle again (with done) at edge idle.
  bit         m_active = 1'b0;
  int         m_acc, m_pend, m_idle;
  logic [1:0] m_idx;
  bit         m_acc_now;
  logic [3:0] exp_q[$];

  typedef struct {
    logic       r, v;
    logic [1:0] d;
    logic       c;
    logic [3:0] k;
    logic       rdy, bsy, dn;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [1:0] key2di(input logic [3:0] k);
    key2di = 2'd0;
    for (int i = 0; i < 4; i++) if (k[i]) key2di = 2'(i);
  endfunction

  task automatic step(input logic r, input logic v, input logic [1:0] d, input logic c);
    int n;
    bit rdy_before;
    logic [3:0] ek;
    logic ebusy, edone;
    rst = r; di_valid = v; di = d; cancel = c;
    n = cyc + 1;
    rdy_before = !(m_active && cyc < m_idle);
    m_acc_now = 1'b0;
    if (r) begin
      m_active = 1'b0;
    end else if (rdy_before && v) begin
      m_active = 1'b1; m_acc_now = 1'b1;
      m_acc = n; m_pend = n + H; m_idle = n + H + G; m_idx = d;
    end else if (m_active && c && n > m_acc && n <= m_pend) begin
      m_pend = n; m_idle = n + G;
    end
    ek    = (m_active && n < m_pend) ? (4'b0001 << m_idx) : 4'b0000;
    ebusy = m_active && n < m_idle;
    edone = m_active && n == m_idle;
    exp_q.push_back(ek);
    @(posedge clk); #1;
    cyc = n;
    chk("keys", {4'b0, keys}, {4'b0, exp_q.pop_front()});
    chk("di_ready", {7'b0, di_ready}, {7'b0, !ebusy});
    chk("busy", {7'b0, busy}, {7'b0, ebusy});
    chk("done", {7'b0, done}, {7'b0, edone});
    if (keys != 4'b0000) begin
      chk("onehot", 8'($countones(keys)), 8'd1);
      chk("key2di", {6'b0, key2di(keys)}, {6'b0, m_idx});
    end
  endtask

  task automatic idle_steps(input int k);
    for (int i = 0; i < k; i++) step(1'b0, 1'b0, 2'd0, 1'b0);
  endtask

  task automatic send(input logic [1:0] d);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      step(1'b0, 1'b1, d, 1'b0);
      ok = m_acc_now;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL accept_timeout cyc=%0d actual=not_accepted expected=accepted", cyc);
    end
  endtask

  initial begin
    // Single press after reset: inputs for the edge, then outputs seen after it.
    tbl[0] = '{1'b0, 1'b1, 2'd2, 1'b0, 4'b0100, 1'b0, 1'b1, 1'b0};
    tbl[1] = '{1'b0, 1'b0, 2'd0, 1'b0, 4'b0100, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 1'b0, 2'd1, 1'b0, 4'b0100, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 2'd3, 1'b0, 4'b0100, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b1};
    tbl[7] = '{1'b0, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0};

    // Reset for two cycles
    step(1'b1, 1'b1, 2'd3, 1'b1);
    step(1'b1, 1'b0, 2'd0, 1'b0);

    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].v, tbl[i].d, tbl[i].c);
      chk("tbl_keys", {4'b0, keys}, {4'b0, tbl[i].k});
      chk("tbl_ready", {7'b0, di_ready}, {7'b0, tbl[i].rdy});
      chk("tbl_busy", {7'b0, busy}, {7'b0, tbl[i].bsy});
      chk("tbl_done", {7'b0, done}, {7'b0, tbl[i].dn});
    end

    // Sweep, each command held until accepted (back-to-back)
    for (int d = 0; d < 4; d++) send(2'(d));
    idle_steps(H + G + 2);

    // Cancel in the second press cycle
    step(1'b0, 1'b1, 2'd1, 1'b0);
    step(1'b0, 1'b0, 2'd1, 1'b0);
    step(1'b0, 1'b0, 2'd1, 1'b1);
    idle_steps(G + 2);

    // Cancel together with a command in IDLE, then cancel during RELEASE
    step(1'b0, 1'b1, 2'd3, 1'b1);
    idle_steps(H);
    step(1'b0, 1'b0, 2'd0, 1'b1);
    idle_steps(G + 1);

    // Reset mid-press
    step(1'b0, 1'b1, 2'd3, 1'b0);
    idle_steps(2);
    step(1'b1, 1'b0, 2'd0, 1'b0);
    idle_steps(H + G + 2);

    // Command offered only during RELEASE is dropped
    step(1'b0, 1'b1, 2'd0, 1'b0);
    idle_steps(H);
    for (int i = 0; i < G; i++) step(1'b0, 1'b1, 2'd3, 1'b0);
    idle_steps(H + 2);

    // Random traffic
    for (int i = 0; i < 600; i++)
      step(($urandom_range(0, 59) == 0), 1'($urandom_range(0, 1)),
           2'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0));
    idle_steps(H + G + 2);

    chk("exp_q_empty", 8'(exp_q.size()), 8'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
